// File: rtl/chien_correct.sv
// ============================================================================
// Module      : chien_correct
// Description : Applies Chien-search root flags to the received bit stream,
//               counts the roots and flags uncorrectable codewords.
//               Optional macro CHIEN_CORRECT_LOC_EN adds loc / loc_valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module chien_correct #(
    parameter int unsigned M = 4,
    parameter int unsigned T = 3,
    parameter int unsigned N = (1 << M) - 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [M-1:0]   deg,
    input  logic           ce,
    input  logic           err,
    input  logic           data_in,
    output logic           data_out,
    output logic           valid_out,
    output logic           last_out,
    output logic           done,
    output logic [M-1:0]   err_count,
`ifdef CHIEN_CORRECT_LOC_EN
    output logic [M*T-1:0] loc,
    output logic           loc_valid,
`endif
    output logic           fail
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [M-1:0] LAST_POS = M'(N - 1);
    localparam logic [M-1:0] T_LIM    = M'(T);
    localparam logic [M-1:0] CNT_MAX  = '1;

    state_t         state_q, state_d;
    logic [M-1:0]   pos_q, pos_d;
    logic [M-1:0]   deg_q, deg_d;
    logic           data_out_q, data_out_d;
    logic           valid_out_q, valid_out_d;
    logic           last_out_q, last_out_d;
    logic           done_q, done_d;
    logic [M-1:0]   err_count_q, err_count_d;
    logic           fail_q, fail_d;
`ifdef CHIEN_CORRECT_LOC_EN
    logic [M*T-1:0] loc_q, loc_d;
    logic           loc_valid_q, loc_valid_d;
`endif

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        deg_d       = deg_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
        done_d      = 1'b0;
        err_count_d = err_count_q;
        fail_d      = fail_q;
`ifdef CHIEN_CORRECT_LOC_EN
        loc_d       = loc_q;
        loc_valid_d = loc_valid_q;
`endif
        // start outranks everything, including the last position of a codeword
        if (start) begin
            state_d     = S_SEARCH;
            pos_d       = '0;
            deg_d       = deg;
            err_count_d = '0;
            fail_d      = 1'b0;
`ifdef CHIEN_CORRECT_LOC_EN
            loc_d       = '0;
            loc_valid_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_SEARCH: begin
                    if (ce) begin
                        data_out_d  = data_in ^ err;
                        valid_out_d = 1'b1;
                        pos_d       = pos_q + 1'b1;
                        if (err) begin
                            if (err_count_q != CNT_MAX) begin
                                err_count_d = err_count_q + 1'b1;
                            end
`ifdef CHIEN_CORRECT_LOC_EN
                            for (int k = 0; k < int'(T); k++) begin
                                if (err_count_q == M'(k)) begin
                                    loc_d[k*M +: M] = pos_q;
                                end
                            end
`endif
                        end
                        if (pos_q == LAST_POS) begin
                            last_out_d = 1'b1;
                            pos_d      = '0;
                            state_d    = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    fail_d  = (err_count_q != deg_q) || (deg_q > T_LIM);
`ifdef CHIEN_CORRECT_LOC_EN
                    loc_valid_d = 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pos_q       <= '0;
            deg_q       <= '0;
            data_out_q  <= 1'b0;
            valid_out_q <= 1'b0;
            last_out_q  <= 1'b0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            fail_q      <= 1'b0;
`ifdef CHIEN_CORRECT_LOC_EN
            loc_q       <= '0;
            loc_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            deg_q       <= deg_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            last_out_q  <= last_out_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
            fail_q      <= fail_d;
`ifdef CHIEN_CORRECT_LOC_EN
            loc_q       <= loc_d;
            loc_valid_q <= loc_valid_d;
`endif
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign fail      = fail_q;
`ifdef CHIEN_CORRECT_LOC_EN
    assign loc       = loc_q;
    assign loc_valid = loc_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_chien_correct.sv
// ============================================================================
// Module      : tb_chien_correct
// Description : Randomised self-checking bench for chien_correct.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chien_correct;

    localparam int M = 4;
    localparam int T = 3;
    localparam int N = 15;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [M-1:0]   deg;
    logic           ce;
    logic           err;
    logic           data_in;
    logic           data_out;
    logic           valid_out;
    logic           last_out;
    logic           done;
    logic [M-1:0]   err_count;
    logic           fail;
`ifdef CHIEN_CORRECT_LOC_EN
    logic [M*T-1:0] loc;
    logic           loc_valid;
`endif

    int checks   = 0;
    int failures = 0;

    chien_correct #(.M(M), .T(T), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .deg       (deg),
        .ce        (ce),
        .err       (err),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .last_out  (last_out),
        .done      (done),
        .err_count (err_count),
`ifdef CHIEN_CORRECT_LOC_EN
        .loc       (loc),
        .loc_valid (loc_valid),
`endif
        .fail      (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One codeword: ev/dv give the per-position root flags and received bits.
    // gap: 0 = ce always high, 1 = ce alternating 1,0,..., 2 = random ce.
    // npos < N stops early so the next start lands on position npos.
    // rst_at >= 0 asserts reset while position rst_at is being presented.
    task automatic run_cw(input int dg, input logic [N-1:0] ev, input logic [N-1:0] dv,
                          input int gap, input int npos, input int rst_at);
        int  sent;
        int  cyc;
        int  nerr;
        int  exp_cnt;
        bit  exp_fail;
        bit  c;
        logic [M*T-1:0] exp_loc;
        int  k;
        start   = 1'b1;
        deg     = dg[M-1:0];
        ce      = 1'b1;
        err     = 1'b1;
        data_in = 1'($urandom);
        tick();
        start = 1'b0;
        check("start_valid", 32'(valid_out), 32'd0);
        check("start_cnt",   32'(err_count), 32'd0);
        check("start_fail",  32'(fail),      32'd0);
        check("start_done",  32'(done),      32'd0);
        sent = 0;
        cyc  = 0;
        while (sent < npos) begin
            if (sent == rst_at) begin
                ce      = 1'b1;
                err     = ev[sent];
                data_in = dv[sent];
                #2 reset = 1'b1;
                #1;
                check("rst_async", 32'({data_out, valid_out, last_out, done, fail, err_count}), 32'd0);
                tick();
                check("rst_hold", 32'({data_out, valid_out, last_out, done, fail, err_count}), 32'd0);
                reset = 1'b0;
                repeat (4) begin
                    ce      = 1'($urandom);
                    err     = 1'($urandom);
                    data_in = 1'($urandom);
                    tick();
                    check("post_rst_idle", 32'({valid_out, last_out, done}), 32'd0);
                end
                return;
            end
            case (gap)
                0:       c = 1'b1;
                1:       c = (cyc % 2 == 0);
                default: c = 1'($urandom_range(0, 1));
            endcase
            ce      = c;
            err     = c ? ev[sent] : 1'($urandom);
            data_in = c ? dv[sent] : 1'($urandom);
            tick();
            cyc++;
            check("no_early_done", 32'(done), 32'd0);
            if (c) begin
                check("valid", 32'(valid_out), 32'd1);
                check("data",  32'(data_out),  32'(dv[sent] ^ ev[sent]));
                check("last",  32'(last_out),  32'(sent == N - 1));
                sent++;
            end else begin
                check("gap_valid", 32'({valid_out, last_out}), 32'd0);
            end
        end
        if (npos < N) return;

        nerr     = $countones(ev);
        exp_cnt  = (nerr > (1 << M) - 1) ? (1 << M) - 1 : nerr;
        exp_fail = (exp_cnt != dg) || (dg > T);
        ce      = 1'($urandom);
        err     = 1'($urandom);
        data_in = 1'($urandom);
        tick();
        check("done_pulse",  32'(done),      32'd1);
        check("done_cnt",    32'(err_count), 32'(exp_cnt));
        check("done_fail",   32'(fail),      32'(exp_fail));
        check("done_valid",  32'({valid_out, last_out}), 32'd0);
`ifdef CHIEN_CORRECT_LOC_EN
        exp_loc = '0;
        k = 0;
        for (int p = 0; p < N; p++) begin
            if (ev[p]) begin
                if (k < T) exp_loc[k*M +: M] = M'(p);
                k++;
            end
        end
        check("loc",       32'(loc),       32'(exp_loc));
        check("loc_valid", 32'(loc_valid), 32'd1);
`else
        exp_loc = '0;
        k = 0;
`endif
        ce  = 1'($urandom);
        err = 1'($urandom);
        tick();
        check("done_once",  32'(done),      32'd0);
        check("idle_valid", 32'(valid_out), 32'd0);
        check("fail_hold",  32'(fail),      32'(exp_fail));
        check("cnt_hold",   32'(err_count), 32'(exp_cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] ev;
        logic [N-1:0] dv;
        int dg;
        reset   = 1'b1;
        start   = 1'b0;
        ce      = 1'b0;
        err     = 1'b0;
        data_in = 1'b0;
        deg     = '0;
        #12;
        check("reset_outs", 32'({data_out, valid_out, last_out, done, fail, err_count}), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            ce      = 1'b1;
            err     = 1'b1;
            data_in = 1'($urandom);
            tick();
            check("idle_ignore", 32'({valid_out, last_out, done, err_count}), 32'd0);
        end

        // error-free, two roots, count mismatch, gapped ce
        run_cw(0, '0, N'($urandom), 0, N, -1);
        ev = '0; ev[3] = 1'b1; ev[9] = 1'b1;
        run_cw(2, ev, N'($urandom), 0, N, -1);
        ev = '0; ev[5] = 1'b1;
        run_cw(3, ev, N'($urandom), 0, N, -1);
        run_cw(0, '0, N'($urandom), 1, N, -1);

        // abort at position 7, then abort on the last position
        ev = '0; ev[2] = 1'b1;
        run_cw(1, ev, N'($urandom), 0, 7, -1);
        ev = '0; ev[4] = 1'b1; ev[13] = 1'b1;
        run_cw(2, ev, N'($urandom), 0, N - 1, -1);
        run_cw(0, '0, N'($urandom), 0, N, -1);

        // reset at position 10, then a normal codeword
        ev = '0; ev[1] = 1'b1; ev[12] = 1'b1;
        run_cw(2, ev, N'($urandom), 0, N, 10);
        ev = '0; ev[0] = 1'b1; ev[14] = 1'b1;
        run_cw(2, ev, N'($urandom), 2, N, -1);

        // deg boundaries around T and an all-roots codeword
        ev = '0; ev[0] = 1'b1; ev[6] = 1'b1; ev[14] = 1'b1;
        run_cw(3, ev, N'($urandom), 0, N, -1);
        ev[8] = 1'b1;
        run_cw(4, ev, N'($urandom), 0, N, -1);
        run_cw(15, '1, N'($urandom), 2, N, -1);

        for (int i = 0; i < 30; i++) begin
            ev = N'($urandom) & N'($urandom) & N'($urandom);
            dv = N'($urandom);
            dg = ($urandom_range(0, 1) == 1) ? $countones(ev) : int'($urandom_range(0, 5));
            run_cw(dg, ev, dv, int'($urandom_range(0, 2)), N, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
